// File: rtl/seg_disp_pkg.sv
// seg_disp_pkg: shared types and constants for the seven-segment display arbiter.
package seg_disp_pkg;
   typedef enum logic {IDLE, OWN} state_t;
   localparam logic [15:0] IDLE_WORD_DEF = 16'hFFFF;
   function automatic int idx_w(input int n);
      return n < 2 ? 1 : $clog2(n);
   endfunction
endpackage

// File: rtl/seg_disp_arbiter_if.sv
// seg_disp_arbiter_if: request/grant/data bundle between applications and the arbiter.
interface seg_disp_arbiter_if import seg_disp_pkg::*; #(
   parameter int N_REQ = 4
);
   logic [N_REQ-1:0]        req;
   logic [16*N_REQ-1:0]     req_data;
   logic [N_REQ-1:0]        gnt;
   logic [idx_w(N_REQ)-1:0] owner;
   logic [15:0]             disp_data;
   logic                    disp_busy;
   modport master (output req, req_data, input gnt, owner, disp_data, disp_busy);
   modport slave  (input req, req_data, output gnt, owner, disp_data, disp_busy);
endinterface

// File: rtl/seg_rr_pick.sv
// seg_rr_pick: combinational round-robin finder starting just after last.
module seg_rr_pick import seg_disp_pkg::*; #(
   parameter int N_REQ = 4,
   localparam int W = idx_w(N_REQ)
) (
   input  logic [N_REQ-1:0] cand,
   input  logic [W-1:0]     last,
   output logic [W-1:0]     pick,
   output logic             found
);
   always_comb begin
      pick = '0;
      found = 1'b0;
      for (int k = 1; k <= N_REQ; k++) begin
         if (!found && cand[(int'(last) + k) % N_REQ]) begin
            found = 1'b1;
            pick = W'((int'(last) + k) % N_REQ);
         end
      end
   end
endmodule

// File: rtl/seg_disp_arbiter.sv
// seg_disp_arbiter: round-robin owner of the 4-digit display with minimum hold time,
// forwarding the owner's hex word to the scan driver.
module seg_disp_arbiter import seg_disp_pkg::*; #(
   parameter int          N_REQ       = 4,
   parameter int          HOLD_CYCLES = 50_000_000,
   parameter logic [15:0] IDLE_WORD   = IDLE_WORD_DEF
) (
   input logic               clk,
   input logic               rst,
   seg_disp_arbiter_if.slave bus
);
   localparam int W  = idx_w(N_REQ);
   localparam int CW = $clog2(HOLD_CYCLES + 1);
   state_t           state, state_n;
   logic [CW-1:0]    cnt, cnt_n;
   logic [W-1:0]     owner, owner_n, last, last_n, pick;
   logic [N_REQ-1:0] gnt, gnt_n, cand;
   logic [15:0]      data, data_n;
   logic             found, release_e, grant_e;
   // while owning, gnt is exactly the owner's bit, so it doubles as the handover mask
   assign cand = state == OWN ? bus.req & ~gnt : bus.req;
   seg_rr_pick #(.N_REQ(N_REQ)) u_pick (.cand(cand), .last(last), .pick(pick), .found(found));
   always_comb begin
      release_e = state == OWN && !bus.req[owner];
      grant_e = found && (state == IDLE || release_e || cnt == '0);
      state_n = state;
      cnt_n = cnt == '0 ? '0 : cnt - 1'b1;
      owner_n = owner;
      last_n = last;
      gnt_n = gnt;
      data_n = state == OWN ? bus.req_data[16*int'(owner) +: 16] : IDLE_WORD;
      if (grant_e) begin
         state_n = OWN;
         cnt_n = CW'(HOLD_CYCLES - 1);
         owner_n = pick;
         last_n = pick;
         gnt_n = N_REQ'(1) << pick;
         data_n = bus.req_data[16*int'(pick) +: 16];
      end else if (release_e) begin
         state_n = IDLE;
         cnt_n = '0;
         owner_n = '0;
         gnt_n = '0;
         data_n = IDLE_WORD;
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt <= '0;
         owner <= '0;
         last <= W'(N_REQ - 1);
         gnt <= '0;
         data <= IDLE_WORD;
      end else begin
         state <= state_n;
         cnt <= cnt_n;
         owner <= owner_n;
         last <= last_n;
         gnt <= gnt_n;
         data <= data_n;
      end
   end
   assign bus.gnt = gnt;
   assign bus.owner = owner;
   assign bus.disp_data = data;
   assign bus.disp_busy = |gnt;
endmodule

// File: tb/tb_seg_disp_arbiter.sv
// tb_seg_disp_arbiter: directed scenarios with an expected-output queue checked after each edge.
module tb_seg_disp_arbiter;
   typedef struct {
      logic [3:0]  g;
      logic [1:0]  o;
      logic [15:0] d;
      logic        b;
      string       tag;
   } exp_t;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int total = 0;
   int bad = 0;
   exp_t q[$];
   seg_disp_arbiter_if #(.N_REQ(4)) bus ();
   seg_disp_arbiter #(.N_REQ(4), .HOLD_CYCLES(8)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   task automatic push(input logic [3:0] g, input logic [1:0] o, input logic [15:0] d, input string tag);
      exp_t e;
      e.g = g;
      e.o = o;
      e.d = d;
      e.b = |g;
      e.tag = tag;
      q.push_back(e);
   endtask
   task automatic chk();
      exp_t e;
      total++;
      assert (q.size() > 0) else begin
         bad++;
         $error("FAIL scoreboard_empty got size=%0d want >0", q.size());
      end
      if (q.size() > 0) begin
         e = q.pop_front();
         total += 4;
         assert (bus.gnt === e.g) else begin
            bad++;
            $error("FAIL %s gnt got=%b want=%b", e.tag, bus.gnt, e.g);
         end
         assert (bus.owner === e.o) else begin
            bad++;
            $error("FAIL %s owner got=%0d want=%0d", e.tag, bus.owner, e.o);
         end
         assert (bus.disp_data === e.d) else begin
            bad++;
            $error("FAIL %s disp_data got=%h want=%h", e.tag, bus.disp_data, e.d);
         end
         assert (bus.disp_busy === e.b) else begin
            bad++;
            $error("FAIL %s disp_busy got=%b want=%b", e.tag, bus.disp_busy, e.b);
         end
      end
   endtask
   task automatic run(input int n, input logic [3:0] g, input logic [1:0] o, input logic [15:0] d, input string tag);
      repeat (n) begin
         push(g, o, d, tag);
         @(posedge clk);
         #1;
         chk();
      end
   endtask
   task automatic setw(input int i, input logic [15:0] w);
      bus.req_data[16*i +: 16] = w;
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end
   initial begin
      bus.req = '0;
      bus.req_data = '0;
      #12;
      push(4'b0000, 2'd0, 16'hFFFF, "reset");
      chk();
      rst = 1'b0;
      run(20, 4'b0000, 2'd0, 16'hFFFF, "idle");
      setw(2, 16'h1234);
      bus.req = 4'b0100;
      run(1, 4'b0100, 2'd2, 16'h1234, "single_grant");
      setw(2, 16'h5678);
      run(1, 4'b0100, 2'd2, 16'h5678, "live_update");
      run(100, 4'b0100, 2'd2, 16'h5678, "hold_alone");
      bus.req = 4'b0000;
      run(1, 4'b0000, 2'd0, 16'hFFFF, "release_idle");
      setw(0, 16'h0001);
      setw(1, 16'h0011);
      setw(3, 16'h0033);
      bus.req = 4'b0001;
      run(1, 4'b0001, 2'd0, 16'h0001, "rr_grant0");
      bus.req = 4'b1011;
      run(7, 4'b0001, 2'd0, 16'h0001, "rr_hold0");
      run(1, 4'b0010, 2'd1, 16'h0011, "rr_preempt1");
      run(7, 4'b0010, 2'd1, 16'h0011, "rr_hold1");
      run(1, 4'b1000, 2'd3, 16'h0033, "rr_preempt3");
      run(7, 4'b1000, 2'd3, 16'h0033, "rr_hold3");
      run(1, 4'b0001, 2'd0, 16'h0001, "rr_back0");
      bus.req = 4'b0000;
      run(1, 4'b0000, 2'd0, 16'hFFFF, "rr_idle");
      setw(2, 16'h0222);
      bus.req = 4'b0100;
      run(1, 4'b0100, 2'd2, 16'h0222, "early_grant2");
      bus.req = 4'b0101;
      run(2, 4'b0100, 2'd2, 16'h0222, "early_hold2");
      bus.req = 4'b0001;
      run(1, 4'b0001, 2'd0, 16'h0001, "early_handover");
      bus.req = 4'b0000;
      run(1, 4'b0000, 2'd0, 16'hFFFF, "early_idle");
      bus.req = 4'b0010;
      run(3, 4'b0010, 2'd1, 16'h0011, "pre_reset_own1");
      #2;
      rst = 1'b1;
      #1;
      push(4'b0000, 2'd0, 16'hFFFF, "async_reset");
      chk();
      bus.req = 4'b1010;
      #2;
      rst = 1'b0;
      run(1, 4'b0010, 2'd1, 16'h0011, "first_after_reset");
      total++;
      assert (q.size() == 0) else begin
         bad++;
         $error("FAIL scoreboard_drain got size=%0d want 0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/seg_disp_arbiter.md
Name: seg_disp_arbiter

Overview:
- Shares the single 4-digit seven-segment display between up to N_REQ requesters, for example a stopwatch, a counter and a status/error source.
- Grants the display by round-robin with a guaranteed minimum hold time per owner.
- Forwards the owner's 16-bit hex word to the digit-scan driver.
- Sits between the application blocks and the scan driver; the scan driver consumes disp_data directly.

Parameters:
- N_REQ, 4, number of requesters; legal range 2..8.
- HOLD_CYCLES, 50_000_000, minimum clk cycles an owner keeps the display once another requester is waiting (0.5 s at 100 MHz); must be at least 1.
- IDLE_WORD, 16'hFFFF, word driven when nobody owns the display; the scanner shows all digits as dash.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, asynchronous, active-high.
- req  input  N_REQ  per-requester display request, level-sensitive.
- req_data  input  16*N_REQ  flattened hex words; requester i occupies bits [16*i+15:16*i].
- gnt  output  N_REQ  one-hot grant, registered; all zeros when idle.
- owner  output  $clog2(N_REQ)  index of the current owner, registered; 0 when idle.
- disp_data  output  16  word to the scan driver, registered.
- disp_busy  output  1  high while any requester owns the display.

Behaviour:
- Clock and reset: one clock domain, clk. rst is asynchronous and active-high.
- Reset values:
  - gnt = 0, owner = 0, disp_busy = 0, disp_data = IDLE_WORD.
  - FSM = IDLE, hold counter = 0.
  - Internal last_owner = N_REQ-1, so requester 0 wins the first arbitration.
- FSM states: IDLE, OWN.
- Round-robin pick: search req starting at index (last_owner+1) mod N_REQ, upward with wrap; the first set bit wins. Candidate set is req with the current owner's bit masked off when arbitrating a handover.
- IDLE:
  - If req != 0 at a rising edge, then on that edge: state becomes OWN, gnt/owner are set to the pick, last_owner is set to the pick, hold counter is loaded with HOLD_CYCLES-1, and disp_data is loaded with the pick's req_data.
  - Latency from req sampled to gnt and disp_data updated is 1 cycle.
  - Otherwise disp_data holds IDLE_WORD.
- OWN:
  - Every edge, disp_data is loaded with the current owner's req_data, so live updates appear with 1-cycle latency.
  - Hold counter decrements by 1 per cycle and saturates at 0.
- Release: if req[owner] is low at an edge, ownership ends on that edge regardless of the counter.
  - If other requests are pending, the next RR pick is granted on the same edge. There is no idle cycle, the counter is reloaded, and disp_data is loaded with the new owner's word.
  - If none are pending, state becomes IDLE, gnt = 0, and disp_data = IDLE_WORD.
- Preemption: if the counter = 0, req[owner] is still high, and another request is pending, hand over to the RR pick on that edge, exactly as in release.
  - If nothing else is pending, the owner keeps the display indefinitely with the counter held at 0.
- Simultaneous events:
  - Release and counter expiry on the same edge are treated as release.
  - New requests arriving during the hold time wait; there is no priority override.
- Width rules:
  - Counter width is $clog2(HOLD_CYCLES+1).
  - disp_data selection is a pure mux; no arithmetic on data.
- Invariants:
  - gnt is always one-hot or zero, and gnt[owner] = disp_busy.
  - A requester never sees gnt while its req is low for more than the 1 cycle of registered lag.
- Reset mid-operation: all outputs return asynchronously to their reset values. After rst deasserts, the first grant goes to the lowest active index.

Decomposition:
- Package seg_disp_pkg holds:
  - the state typedef (IDLE, OWN);
  - the IDLE_WORD default;
  - the helper constant for N_REQ index width.
- One natural sub-module, seg_rr_pick: combinational round-robin finder.
  - Inputs: candidate mask, last_owner.
  - Outputs: pick index and found flag.
  - Instantiated once; used for both IDLE grant and handover.

Test Plan:
All scenarios use HOLD_CYCLES=8 and N_REQ=4.
- Reset then idle: release rst with req=0 -> disp_data=16'hFFFF, gnt=0, disp_busy=0 for 20 cycles.
- Single requester: req=4'b0100 with word2=16'h1234 -> next edge gnt=4'b0100, owner=2, disp_data=16'h1234. Changing word2 to 16'h5678 appears 1 cycle later. Keeping req high for 100 cycles alone keeps the grant.
- Round-robin preemption: req0 granted (word0=16'h0001), then req1 and req3 raised -> gnt switches to 4'b0010 exactly 8 cycles after req0's grant, then to 4'b1000 8 cycles later, then back to 4'b0001.
- Early release handover: req2 owns, req0 waiting, req2 drops at hold cycle 3 -> on that edge gnt=4'b0001 and disp_data=word0, with no cycle where disp_busy=0.
- Release to idle: sole owner drops req -> next edge gnt=0 and disp_data=16'hFFFF.
- Reset mid-operation: assert rst while req1 owns -> gnt=0 and disp_data=16'hFFFF immediately without waiting for a clk edge. After release with req=4'b1010, the first grant goes to 4'b0010.
